// File: rtl/wpu_readback.sv
// wpu_readback: walks the reduced-weight and compensation memories in address
// order and rebuilds each approximate 8-bit weight. Every weight is streamed out
// over a valid/ready handshake. Compensation entries whose row tag does not
// match, or a flagged weight that arrives after the compensation pointer is
// full, raise a sticky error.
module wpu_readback #(
    parameter int NUM_W  = 64,
    parameter int ROWS   = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [4:0]        w_rd_data,
    output logic              c_rd_en,
    output logic [ADDR_W-1:0] c_rd_addr,
    input  logic [5:0]        c_rd_data,
    output logic [7:0]        out_weight,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_col_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              comp_err,
    output logic [ADDR_W:0]   comp_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUTPUT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(NUM_W - 1);
    localparam logic [ADDR_W:0]   C_FULL   = (ADDR_W + 1)'(NUM_W);
    localparam logic [ADDR_W-1:0] W_ONE    = {{(ADDR_W - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   C_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [2:0]        ROW_LAST = 3'(ROWS - 1);

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   w_ptr_r;
    logic [ADDR_W:0]     c_ptr_r;
    logic [7:0]          out_weight_r;
    logic [ADDR_W-1:0]   out_addr_r;
    logic                out_valid_r;
    logic                comp_err_r;

    logic                flag_s;
    logic                c_full_s;
    logic [2:0]          cw_s;
    logic                row_bad_s;

    // Rebuild the weight: flagged entries take the low bits from the compensation
    // word, unflagged ones replicate the nibble MSB upward. Bit 0 was dropped by the
    // encoder and always comes back as zero.
    function automatic logic [7:0] rebuild(input logic [4:0] w, input logic [2:0] cw);
        logic [7:0] r;
        if (w[4]) begin
            r = {w[3:0], cw, 1'b0};
        end else begin
            r = {w[3], w[3], w[3], w[3:0], 1'b0};
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. out_ready only reaches the outputs through this register.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE:   state_s = S_CAPTURE;
            S_CAPTURE: state_s = S_OUTPUT;
            S_OUTPUT: begin
                if (!out_ready) begin
                    state_s = S_OUTPUT;
                end else if (w_ptr_r == W_LAST) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Decode the read data captured this cycle. A full compensation pointer forces
    // cw to zero and counts as an error.
    always_comb begin
        flag_s   = w_rd_data[4];
        c_full_s = (c_ptr_r == C_FULL);
        if (c_full_s) begin
            cw_s      = 3'b000;
            row_bad_s = 1'b1;
        end else begin
            cw_s      = c_rd_data[2:0];
            row_bad_s = (c_rd_data[5:3] != w_ptr_r[2:0]);
        end
    end

    // Pointers, output beat and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_r      <= '0;
            c_ptr_r      <= '0;
            out_weight_r <= 8'h00;
            out_addr_r   <= '0;
            out_valid_r  <= 1'b0;
            comp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        w_ptr_r    <= '0;
                        c_ptr_r    <= '0;
                        comp_err_r <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    out_weight_r <= rebuild(w_rd_data, cw_s);
                    out_addr_r   <= w_ptr_r;
                    out_valid_r  <= 1'b1;
                    if (flag_s) begin
                        if (row_bad_s) begin
                            comp_err_r <= 1'b1;
                        end
                        if (!c_full_s) begin
                            c_ptr_r <= c_ptr_r + C_ONE;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (w_ptr_r != W_LAST) begin
                            w_ptr_r <= w_ptr_r + W_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (state_r != S_IDLE);
    assign done         = (state_r == S_DONE);
    assign w_rd_en      = (state_r == S_ISSUE);
    assign c_rd_en      = (state_r == S_ISSUE);
    assign w_rd_addr    = w_ptr_r;
    assign c_rd_addr    = c_ptr_r[ADDR_W-1:0];
    assign out_weight   = out_weight_r;
    assign out_addr     = out_addr_r;
    assign out_valid    = out_valid_r;
    assign out_col_last = out_valid_r && (out_addr_r[2:0] == ROW_LAST);
    assign comp_err     = comp_err_r;
    assign comp_count   = c_ptr_r;

endmodule

// File: tb/tb_wpu_readback.sv
// Directed testbench for wpu_readback with registered-read memory models.
module tb_wpu_readback;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       w_rd_en;
    logic [5:0] w_rd_addr;
    logic [4:0] w_rd_data;
    logic       c_rd_en;
    logic [5:0] c_rd_addr;
    logic [5:0] c_rd_data;
    logic [7:0] out_weight;
    logic [5:0] out_addr;
    logic       out_col_last;
    logic       out_valid;
    logic       out_ready;
    logic       comp_err;
    logic [6:0] comp_count;

    always #5 clk = ~clk;

    wpu_readback #(.NUM_W(64), .ROWS(8), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data),
        .out_weight(out_weight), .out_addr(out_addr), .out_col_last(out_col_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .comp_err(comp_err), .comp_count(comp_count)
    );

    logic [4:0] wmem [64];
    logic [5:0] cmem [64];
    logic [5:0] issue_caddr [64];
    int rd_cnt   = 0;
    int acc_cnt  = 0;
    int acc10    = 0;
    int done_cnt = 0;

    int checks   = 0;
    int failures = 0;
    int ci       = 0;
    int col_last_cnt = 0;

    // Memories with one cycle read latency
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (c_rd_en) c_rd_data <= cmem[c_rd_addr];
    end

    // Event monitors
    always @(posedge clk) begin
        if (w_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            issue_caddr[w_rd_addr] <= c_rd_addr;
        end
        if (out_valid && out_ready) begin
            acc_cnt <= acc_cnt + 1;
            if (out_addr == 6'd10) acc10 <= acc10 + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] ref_weight(input logic [4:0] w, input logic [2:0] cw);
        logic [7:0] r;
        if (w[4]) r = {w[3:0], cw, 1'b0};
        else      r = {{3{w[3]}}, w[3:0], 1'b0};
        return r;
    endfunction

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic load_a();
        for (int a = 0; a < 64; a++) begin
            wmem[a] = {((a % 3) == 0) ? 1'b1 : 1'b0, 4'(a * 5 + 3)};
            cmem[a] = {3'(a * 3), 3'(a + 1)};
        end
        wmem[0] = 5'h15;
        wmem[1] = 5'h06;
        wmem[2] = 5'h09;
        cmem[0] = {3'b000, 3'b101};
    endtask

    task automatic load_b();
        for (int a = 0; a < 64; a++) begin
            wmem[a] = {1'b0, 4'(a)};
            cmem[a] = 6'h00;
        end
        wmem[13] = {1'b1, 4'hA};
        cmem[0]  = {3'd3, 3'd6};
    endtask

    task automatic run_beats(input int first, input int last, input bit bp);
        logic [4:0] w;
        logic [2:0] cwv;
        logic [7:0] ew;
        int rd0;
        for (int b = first; b <= last; b++) begin
            wait_valid(12);
            chk("beat_valid", {31'd0, out_valid}, 32'd1);
            chk("beat_addr", {26'd0, out_addr}, 32'(b));
            w = wmem[b];
            if (w[4]) begin
                cwv = cmem[ci][2:0];
                ci++;
            end else begin
                cwv = 3'b000;
            end
            ew = ref_weight(w, cwv);
            chk("beat_weight", {24'd0, out_weight}, {24'd0, ew});
            chk("beat_col_last", {31'd0, out_col_last}, {31'd0, ((b % 8) == 7)});
            if (out_col_last) col_last_cnt++;
            if (bp && b == 10) begin
                out_ready = 1'b0;
                rd0 = rd_cnt;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", {31'd0, out_valid}, 32'd1);
                    chk("bp_weight", {24'd0, out_weight}, {24'd0, ew});
                    chk("bp_addr", {26'd0, out_addr}, 32'd10);
                end
                chk("bp_no_reads", 32'(rd_cnt), 32'(rd0));
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    int rd_base, acc_base, acc10_base, done_base;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        load_a();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_weight", {24'd0, out_weight}, 32'd0);
        chk("rst_rd_en", {30'd0, w_rd_en, c_rd_en}, 32'd0);
        chk("rst_count", {25'd0, comp_count}, 32'd0);
        chk("rst_err", {31'd0, comp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass A: full pass with flags every third address and one stall
        rd_base = rd_cnt; acc_base = acc_cnt; acc10_base = acc10; done_base = done_cnt;
        ci = 0; col_last_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("issue_busy", {31'd0, busy}, 32'd1);
        chk("issue_rd_en", {30'd0, w_rd_en, c_rd_en}, 32'd3);
        chk("issue_addrs", {20'd0, w_rd_addr, c_rd_addr}, 32'd0);
        @(negedge clk);
        chk("capture_valid", {31'd0, out_valid}, 32'd0);
        chk("capture_rd_en", {31'd0, w_rd_en}, 32'd0);
        @(negedge clk);
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_weight", {24'd0, out_weight}, 32'h5A);
        chk("first_addr", {26'd0, out_addr}, 32'd0);
        chk("first_count", {25'd0, comp_count}, 32'd1);
        chk("first_err", {31'd0, comp_err}, 32'd0);
        run_beats(0, 0, 1'b0);
        wait_valid(12);
        chk("unflag_pos", {24'd0, out_weight}, 32'h0C);
        chk("unflag_count", {25'd0, comp_count}, 32'd1);
        run_beats(1, 1, 1'b0);
        wait_valid(12);
        chk("unflag_neg", {24'd0, out_weight}, 32'hF2);
        run_beats(2, 63, 1'b1);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("done_low", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("pass_count", {25'd0, comp_count}, 32'd22);
        chk("pass_err", {31'd0, comp_err}, 32'd0);
        chk("pass_beats", 32'(acc_cnt - acc_base), 32'd64);
        chk("pass_reads", 32'(rd_cnt - rd_base), 32'd64);
        chk("beat10_once", 32'(acc10 - acc10_base), 32'd1);
        chk("done_once", 32'(done_cnt - done_base), 32'd1);
        chk("col_last_cnt", 32'(col_last_cnt), 32'd8);
        chk("cptr_addr1", {26'd0, issue_caddr[1]}, 32'd1);
        chk("cptr_addr2", {26'd0, issue_caddr[2]}, 32'd1);
        chk("cptr_addr3", {26'd0, issue_caddr[3]}, 32'd1);
        chk("cptr_addr4", {26'd0, issue_caddr[4]}, 32'd2);

        // Pass B: row mismatch at address 13
        load_b();
        ci = 0;
        done_base = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_beats(0, 12, 1'b0);
        wait_valid(12);
        chk("mm_weight", {24'd0, out_weight}, 32'hAC);
        chk("mm_err", {31'd0, comp_err}, 32'd1);
        chk("mm_count", {25'd0, comp_count}, 32'd1);
        run_beats(13, 63, 1'b0);
        chk("mm_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        chk("mm_err_sticky", {31'd0, comp_err}, 32'd1);
        chk("mm_done_once", 32'(done_cnt - done_base), 32'd1);

        // Pass C: new start clears the error, then reset mid-pass
        load_a();
        ci = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_err", {31'd0, comp_err}, 32'd0);
        chk("start_clears_cnt", {25'd0, comp_count}, 32'd0);
        run_beats(0, 19, 1'b0);
        wait_valid(12);
        chk("pre_rst_addr", {26'd0, out_addr}, 32'd20);
        chk("pre_rst_count", {25'd0, comp_count}, 32'd7);
        done_base = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_weight", {24'd0, out_weight}, 32'd0);
        chk("mid_rst_addr", {26'd0, out_addr}, 32'd0);
        chk("mid_rst_count", {25'd0, comp_count}, 32'd0);
        chk("mid_rst_rdaddr", {20'd0, w_rd_addr, c_rd_addr}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        chk("post_rst_no_done", 32'(done_cnt - done_base), 32'd0);
        ci = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(12);
        chk("restart_addr", {26'd0, out_addr}, 32'd0);
        chk("restart_weight", {24'd0, out_weight}, 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wpu_readback.md
Name: wpu_readback

Overview:
- Decode side of the weight preprocessing path for the 8x8 systolic array.
- Walks the 64-entry reduced-weight memory and the packed compensation memory in address order.
- Rebuilds the approximate 8-bit weight for every address and streams it out over a valid/ready interface.
- Used for weight-memory readback, debug and self-check; it also flags compensation entries whose row tag does not match.

Parameters:
- NUM_W, 64, number of weight addresses walked (must equal ROWS × columns).
- ROWS, 8, rows per column; used to derive the row index and the column-end marker.
- ADDR_W, 6, width of the weight and compensation memory addresses.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a full readback pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a pass.
- w_rd_en  out  1  reduced-weight memory read enable.
- w_rd_addr  out  ADDR_W  reduced-weight memory address.
- w_rd_data  in  5  {flag, nibble}; valid one cycle after w_rd_en.
- c_rd_en  out  1  compensation memory read enable.
- c_rd_addr  out  ADDR_W  compensation memory address (packed pointer).
- c_rd_data  in  6  {row[2:0], cw[2:0]}; valid one cycle after c_rd_en.
- out_weight  out  8  reconstructed weight.
- out_addr  out  ADDR_W  weight address of out_weight.
- out_col_last  out  1  out_addr[2:0] == ROWS-1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- comp_err  out  1  sticky compensation row mismatch or pointer overflow.
- comp_count  out  ADDR_W+1  compensation entries consumed in this pass.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; w_ptr=0; c_ptr=0; every output is 0.
- States and transitions:
  - IDLE: start=1 clears comp_err, comp_count, w_ptr and c_ptr, then goes to ISSUE.
  - ISSUE: drives w_rd_en=c_rd_en=1, w_rd_addr=w_ptr, c_rd_addr=c_ptr; goes to CAPTURE.
  - CAPTURE: both read data are valid; register the output; out_valid=1 from the next edge; goes to OUTPUT.
  - OUTPUT: holds out_weight, out_addr and out_valid stable until out_ready=1. On the accepting edge: if w_ptr==NUM_W-1 go to DONE, else w_ptr+1 and go to ISSUE. out_valid drops on the same edge.
  - DONE: done=1 for exactly one cycle; goes to IDLE.
- Throughput is one weight per 3 cycles with no backpressure. First out_valid appears 3 cycles after start is sampled.
- Reconstruction, with f=w_rd_data[4], n=w_rd_data[3:0]:
  - f=1: out_weight = {n, cw, 1'b0}. Check c_rd_data.row == w_ptr[2:0]; a mismatch sets comp_err. Then c_ptr+1 and comp_count+1, both updated in CAPTURE.
  - f=0: out_weight = {n[3], n[3], n[3], n, 1'b0}, i.e. sign-style replication of the top bits. c_ptr is unchanged and c_rd_data is ignored.
  - Bit 0 is always 0, because the encoding drops the weight LSB.
- Compensation read is speculative: it is issued every ISSUE at c_ptr and used only when f=1.
- If f=1 while c_ptr==NUM_W (pointer already full): set comp_err, do not increment c_ptr, force cw=000.
- start in any state other than IDLE is ignored. start held high through DONE begins a new pass on the following IDLE cycle.
- out_col_last is combinational from out_addr and is qualified only by out_valid.
- comp_err holds until the next accepted start or a reset.
- rst_n asserted mid-pass aborts immediately: no done pulse, outputs return to 0. A new pass requires a fresh start.
- No combinational path from out_ready to any output except through the state register.

Test Plan:
- Single flagged weight: addr 0 holds 0x15, comp entry 0 = {000,101}, out_ready=1 → out_weight=0x5A, out_addr=0, comp_count=1, comp_err=0.
- Unflagged weights: addr 1=0x06 → 0x0C; addr 2=0x09 → 0xF2. c_ptr must not move (c_rd_addr stays 1 for the following ISSUE cycles).
- Full pass: 64 addresses, flags at every 3rd address, out_ready=1 → 64 beats, out_col_last high on addrs 7, 15, … 63, done pulses once 1 cycle after beat 64, comp_count=22, busy low after done.
- Backpressure: out_ready held 0 for 5 cycles on beat 10 → out_weight and out_addr stable, no further memory reads, the beat accepted exactly once.
- Row mismatch: addr 13 flagged, comp entry row=3 (expected 5) → comp_err=1 stays high until the next start; the pass completes normally.
- Reset mid-pass: rst_n low at beat 20 → all outputs 0 the same cycle, no done; a new start produces addr 0 first.
